// File: rtl/exu_pkg.sv
// Shared encodings for the execute unit: ALU control, M-extension funct3,
// operand-select codes and FSM state type.
package exu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1101;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic       ASRC_RS1  = 1'b0;
  localparam logic       ASRC_PC   = 1'b1;

  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;
  localparam logic [1:0] BSRC_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exu_iter_alu.sv
// Combinational single-cycle ALU; ctrl_i[2:0] selects the operation and
// ctrl_i[3] is the sub/unsigned/arithmetic modifier.
module exu_iter_alu
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      ctrl_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt;

  always_comb begin
    shamt = b_i[SHW-1:0];
    lt    = ctrl_i[3] ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
    y_o   = '0;
    case (ctrl_i[2:0])
      ALU_ADD[2:0]:   y_o = ctrl_i[3] ? (a_i - b_i) : (a_i + b_i);
      ALU_SLL[2:0]:   y_o = a_i << shamt;
      ALU_SLT[2:0]:   y_o = {{(XLEN-1){1'b0}}, lt};
      ALU_PASSB[2:0]: y_o = b_i;
      ALU_XOR[2:0]:   y_o = a_i ^ b_i;
      ALU_SRL[2:0]: begin
        // Separate branches keep the arithmetic shift in a signed context
        if (ctrl_i[3]) y_o = $signed(a_i) >>> shamt;
        else           y_o = a_i >> shamt;
      end
      ALU_OR[2:0]:    y_o = a_i | b_i;
      ALU_AND[2:0]:   y_o = a_i & b_i;
      default:        y_o = '0;
    endcase
  end

endmodule

// File: rtl/exu_iter.sv
// Execute unit: 1-cycle ALU plus iterative RV-M multiply/divide with
// valid/ready on both sides. Define EXU_ITER_FAST_MUL_EN for a 1-cycle multiplier.
module exu_iter
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      op,
  input  logic            asrc,
  input  logic [1:0]      bsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  localparam int              SHW      = $clog2(XLEN);
  localparam int              PW       = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [SHW:0]    cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;

  logic            accept;
  logic [XLEN-1:0] opa, opb, alu_y;
  logic [2:0]      f3;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign res       = res_q;
  assign accept    = in_valid & in_ready;
  assign f3        = op[2:0];

  always_comb begin
    opa = (asrc == ASRC_PC) ? pc : src1;
    opb = '0;
    case (bsrc)
      BSRC_RS2:  opb = src2;
      BSRC_IMM:  opb = imm;
      BSRC_FOUR: opb = XLEN'(4);
      default:   opb = '0;
    endcase
  end

  exu_iter_alu #(.XLEN(XLEN)) u_alu (
    .a_i    (opa),
    .b_i    (opb),
    .ctrl_i (op[3:0]),
    .y_o    (alu_y)
  );

  // Launch decode: signedness, magnitudes and divide special cases
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div0, div_ovf, mul_neg, div_neg;
  logic [XLEN-1:0] a_mag, b_mag, div_spec;

  always_comb begin
    a_sgn    = f3[2] ? ~f3[0] : ((f3 == MD_MULH) || (f3 == MD_MULHSU));
    b_sgn    = f3[2] ? ~f3[0] : (f3 == MD_MULH);
    a_neg    = a_sgn & opa[XLEN-1];
    b_neg    = b_sgn & opb[XLEN-1];
    a_mag    = a_neg ? -opa : opa;
    b_mag    = b_neg ? -opb : opb;
    div0     = (opb == '0);
    div_ovf  = ~f3[0] & (opa == SMIN) & (opb == '1);
    mul_neg  = a_neg ^ b_neg;
    div_neg  = f3[1] ? a_neg : (a_neg ^ b_neg);
    if (div0) div_spec = f3[1] ? opa : '1;
    else      div_spec = f3[1] ? '0 : opa;
  end

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag,
                                               input logic              neg,
                                               input logic [2:0]        fn);
    logic [2*XLEN-1:0] prod;
    prod = neg ? -mag : mag;
    return (fn == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

`ifdef EXU_ITER_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  // p_q holds {hi, lo}: multiply keeps the multiplier in lo and shifts right;
  // divide keeps the dividend/quotient in lo and the remainder in hi.
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN+1:0] div_trial;
  logic [PW-1:0]   p_nx;
  logic [XLEN-1:0] div_val, calc_res;

  always_comb begin
    mul_sum   = p_q[PW-1:XLEN] + (p_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_trial = {1'b0, div_shift} - {2'b00, dvs_q};
    if (!f3_q[2])
      p_nx = {1'b0, mul_sum, p_q[XLEN-1:1]};
    else if (div_trial[XLEN+1])
      p_nx = {1'b0, div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
    else
      p_nx = {1'b0, div_trial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};

    div_val = f3_q[1] ? p_nx[2*XLEN-1:XLEN] : p_nx[XLEN-1:0];
    if (f3_q[2]) calc_res = neg_q ? -div_val : div_val;
    else         calc_res = mul_pick(p_nx[2*XLEN-1:0], neg_q, f3_q);
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvs_d   = dvs_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    case (state_q)
      CALC: begin
        // The final step and the result write share one cycle
        p_d   = p_nx;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = calc_res;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          if (!op[4]) begin
            res_d   = alu_y;
            state_d = DONE;
          end else if (f3[2] && (div0 || div_ovf)) begin
            res_d   = div_spec;
            state_d = DONE;
          end
`ifdef EXU_ITER_FAST_MUL_EN
          else if (!f3[2]) begin
            res_d   = mul_pick(fast_prod, mul_neg, f3);
            state_d = DONE;
          end
`endif
          else begin
            state_d = CALC;
            cnt_d   = CNT_INIT;
            f3_d    = f3;
            neg_d   = f3[2] ? div_neg : mul_neg;
            dvs_d   = f3[2] ? b_mag : a_mag;
            p_d     = {{(XLEN+1){1'b0}}, (f3[2] ? a_mag : b_mag)};
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      dvs_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvs_q   <= dvs_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: tb/tb_exu_iter.sv
// Bench for exu_iter: latency/result model of the 32-bit unit checked every
// cycle, directed vectors with literal results, plus a small 64-bit instance.
module tb_exu_iter;

`ifdef EXU_ITER_FAST_MUL_EN
  localparam int MUL_LAT   = 1;
  localparam int MUL_LAT64 = 1;
`else
  localparam int MUL_LAT   = 33;
  localparam int MUL_LAT64 = 65;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy, asrc;
  logic [31:0] src1, src2, pc, imm, res;
  logic [4:0]  op;
  logic [1:0]  bsrc;

  logic        in_valid64, in_ready64, out_valid64, busy64;
  logic [63:0] s1_64, s2_64, res64;
  logic [4:0]  op64;

  int unsigned npass = 0;
  int unsigned ntot  = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  exu_iter #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .pc(pc), .imm(imm), .op(op), .asrc(asrc),
    .bsrc(bsrc), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .busy(busy)
  );

  exu_iter #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .src1(s1_64), .src2(s2_64), .pc(64'd0), .imm(64'd0), .op(op64),
    .asrc(1'b0), .bsrc(2'b00), .out_valid(out_valid64), .out_ready(1'b1),
    .res(res64), .busy(busy64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model (RV semantics, plain arithmetic) ----------------
  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!o[4]) begin
      case (o[2:0])
        3'd0: return o[3] ? a - b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return o[3] ? {31'd0, a < b} : {31'd0, ia < ib};
        3'd3: return b;
        3'd4: return a ^ b;
        3'd5: return o[3] ? 32'(ia >>> b[4:0]) : a >> b[4:0];
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    case (o[2:0])
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!o[4]) return 1;
    if (!o[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0, m_pend = '0;
  int          m_left = 0;

  function automatic logic exp_ready();
    return (m_left == 0) && (!m_valid || out_ready);
  endfunction

  initial begin : model
    logic [31:0] ma, mb;
    int          l;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b0;
        m_left  = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_res   = m_pend;
        end
      end else if (in_valid && exp_ready()) begin
        ma = asrc ? pc : src1;
        case (bsrc)
          2'b00:   mb = src2;
          2'b01:   mb = imm;
          2'b10:   mb = 32'd4;
          default: mb = 32'd0;
        endcase
        l = ref_latency(op, ma, mb);
        if (l == 1) begin
          m_valid = 1'b1;
          m_res   = ref_result(op, ma, mb);
        end else begin
          m_valid = 1'b0;
          m_left  = l - 1;
          m_pend  = ref_result(op, ma, mb);
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check("busy", {63'd0, busy}, {63'd0, m_left > 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready()});
        if (m_valid) check("res", {32'd0, res}, {32'd0, m_res});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [4:0] o, input logic as, input logic [1:0] bs,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i);
    int n;
    op = o; asrc = as; bsrc = bs; src1 = a; src2 = b; pc = p; imm = i;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom; pc = $urandom; imm = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] o, input logic as,
                        input logic [1:0] bs, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(o, as, bs, a, b, p, i);
    wait_done(lat);
    check(name, {32'd0, res}, {32'd0, exp});
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run64(input string name, input logic [4:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int n, lat;
    op64 = o; s1_64 = a; s2_64 = b; in_valid64 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, res64, exp);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; pc = '0; imm = '0; op = '0; asrc = 1'b0; bsrc = 2'b00;
    in_valid64 = 1'b0; s1_64 = '0; s2_64 = '0; op64 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_res", {32'd0, res}, 64'd0);
    chk_en = 1'b1;

    // ALU
    run_op("add",   5'b0_0000, 1'b0, 2'b00, 32'd5, 32'd7, 0, 0, 32'd12, 1);
    run_op("sub",   5'b0_1000, 1'b0, 2'b00, 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 1);
    run_op("slt",   5'b0_0010, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 1);
    run_op("sltu",  5'b0_1010, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 1);
    run_op("sra",   5'b0_1101, 1'b0, 2'b00, 32'h8000_0000, 32'd4, 0, 0, 32'hF800_0000, 1);
    run_op("sll31", 5'b0_0001, 1'b0, 2'b00, 32'd1, 32'd31, 0, 0, 32'h8000_0000, 1);
    run_op("srl_wrap", 5'b0_0101, 1'b0, 2'b00, 32'h8000_0000, 32'd36, 0, 0, 32'h0800_0000, 1);
    run_op("pc_plus4", 5'b0_0000, 1'b1, 2'b10, 32'd0, 32'd0, 32'h100, 0, 32'h104, 1);
    run_op("xor_imm", 5'b0_0100, 1'b0, 2'b01, 32'hFF, 32'd0, 0, 32'h20, 32'hDF, 1);
    run_op("passb_zero", 5'b0_0011, 1'b0, 2'b11, 32'd9, 32'h55, 0, 0, 32'd0, 1);

    // Multiply
    run_op("mul",    5'b1_0000, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd3, 0, 0, 32'hFFFF_FFFD, MUL_LAT);
    run_op("mulh",   5'b1_0001, 1'b0, 2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, MUL_LAT);
    run_op("mulhsu", 5'b1_0010, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu",  5'b1_0011, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, MUL_LAT);

    // Divide, including special cases
    run_op("div",     5'b1_0100, 1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFD, 33);
    run_op("rem",     5'b1_0110, 1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 33);
    run_op("divu",    5'b1_0101, 1'b0, 2'b00, 32'd100, 32'd7, 0, 0, 32'd14, 33);
    run_op("rem_pos", 5'b1_0110, 1'b0, 2'b00, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'd1, 33);
    run_op("divu_0",  5'b1_0101, 1'b0, 2'b00, 32'h1234, 32'd0, 0, 0, 32'hFFFF_FFFF, 1);
    run_op("remu_0",  5'b1_0111, 1'b0, 2'b00, 32'h1234, 32'd0, 0, 0, 32'h1234, 1);
    run_op("div_ovf", 5'b1_0100, 1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 1);
    run_op("rem_ovf", 5'b1_0110, 1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 1);

    // Backpressure then back-to-back accept
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(5'b0_0000, 1'b0, 2'b00, 32'd1, 32'd2, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_res", {32'd0, res}, 64'd3);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    op = 5'b0_1000; asrc = 1'b0; bsrc = 2'b00; src1 = 32'd10; src2 = 32'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_res", {32'd0, res}, 64'd7);

    // Reset in the middle of an iterative divide
    @(posedge clk);
    #1;
    issue(5'b1_0101, 1'b0, 2'b00, 32'd1000, 32'd3, 0, 0);
    repeat (22) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    run_op("div_after_rst", 5'b1_0100, 1'b0, 2'b00, 32'd100, 32'hFFFF_FFF9, 0, 0, 32'hFFFF_FFF2, 33);

    // 64-bit instance
    run64("sra64", 5'b0_1101, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run64("mulhu64", 5'b1_0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT64);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
